// File: rtl/tap_lfsr_generator_pkg.sv
// Shared types and helpers for the tap-driven LFSR byte generator.
package rm_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } gen_state_t;

   localparam int          TAP_BYTE_W   = 8;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2F35;

   // Width of the index field taken from each tap slot
   function automatic int tap_idx_w(input int size);
      if (size < 2) begin
         return 1;
      end else begin
         return $clog2(size);
      end
   endfunction

endpackage

// File: rtl/tap_lfsr_generator_feedback.sv
// Combinational feedback for the Fibonacci LFSR: decodes tap slots and XORs the indexed state bits.
module tap_feedback
   import rm_pkg::*;
#(
   parameter int NUM_OF_TAPS = 15,
   parameter int SIZE        = 32
) (
   input  logic [SIZE-1:0]                   state,
   input  logic [NUM_OF_TAPS*TAP_BYTE_W-1:0] taps,
   output logic                              fb
);

   localparam int TW = tap_idx_w(SIZE);

   logic [NUM_OF_TAPS-1:0] hit_s;

   for (genvar k = 0; k < NUM_OF_TAPS; k++) begin : g_slot
      logic [TAP_BYTE_W-1:0] slot_s;
      logic [TW-1:0]         idx_s;

      assign slot_s = taps[k*TAP_BYTE_W +: TAP_BYTE_W];
      assign idx_s  = slot_s[TW-1:0];
      // A zero slot or an index beyond the register width contributes nothing
      assign hit_s[k] = (slot_s != 8'd0) && (32'(idx_s) < SIZE) && state[idx_s];
   end

   assign fb = ^hit_s;

endmodule

// File: rtl/tap_lfsr_generator.sv
// Latches a tap set, runs a Fibonacci LFSR and streams its output as bytes over valid/ready.
// Optional LFSR_LOCKUP_RECOVERY_EN reloads SEED when the register is all-zero and adds a lockup pulse output.
module tap_lfsr_generator
   import rm_pkg::*;
#(
   parameter int          NUM_OF_TAPS = 15,
   parameter int          SIZE        = 32,
   parameter logic [31:0] SEED        = DEFAULT_SEED
) (
   input  logic                              clk,
   input  logic                              res,
   input  logic                              ena,
   input  logic [NUM_OF_TAPS*TAP_BYTE_W-1:0] taps,
   input  logic                              taps_done,
   output logic [7:0]                        dout,
   output logic                              dout_valid,
   input  logic                              dout_ready,
   output logic                              running
`ifdef LFSR_LOCKUP_RECOVERY_EN
   ,
   output logic                              lockup
`endif
);

   gen_state_t                        state_q;
   logic [NUM_OF_TAPS*TAP_BYTE_W-1:0] tap_q;
   logic [SIZE-1:0]                   lfsr_q, lfsr_d;
   logic [6:0]                        sh_q, sh_d;
   logic [2:0]                        bit_cnt_q, bit_cnt_d;
   logic [7:0]                        dout_q;
   logic                              dout_valid_q;
   logic                              running_q;
   logic                              fb_s, out_bit_s, wrap_s, full_s, accept_s, step_s;
`ifdef LFSR_LOCKUP_RECOVERY_EN
   logic                              lockup_q, lockup_d;
`endif

   tap_feedback #(
      .NUM_OF_TAPS (NUM_OF_TAPS),
      .SIZE        (SIZE)
   ) u_tap_feedback (
      .state (lfsr_q),
      .taps  (tap_q),
      .fb    (fb_s)
   );

   always_comb begin
      out_bit_s = lfsr_q[SIZE-1];
      lfsr_d    = {lfsr_q[SIZE-2:0], fb_s};
`ifdef LFSR_LOCKUP_RECOVERY_EN
      lockup_d  = 1'b0;
      if (lfsr_q == '0) begin
         lfsr_d   = SEED[SIZE-1:0];
         lockup_d = 1'b1;
      end else begin
         lockup_d = 1'b0;
      end
`endif
      sh_d      = {sh_q[5:0], out_bit_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      wrap_s    = (bit_cnt_q == 3'd7);
      full_s    = dout_valid_q && !dout_ready;
      accept_s  = dout_valid_q && dout_ready;
      // Mid-byte steps always proceed; the completing step never overwrites an unaccepted byte
      step_s    = (state_q == ST_RUN) && taps_done &&
                  (!full_s || ((bit_cnt_q != 3'd0) && !wrap_s));
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q      <= ST_IDLE;
         tap_q        <= '0;
         lfsr_q       <= '0;
         sh_q         <= 7'd0;
         bit_cnt_q    <= 3'd0;
         dout_q       <= 8'd0;
         dout_valid_q <= 1'b0;
         running_q    <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVERY_EN
         lockup_q     <= 1'b0;
`endif
      end else if (ena) begin
`ifdef LFSR_LOCKUP_RECOVERY_EN
         lockup_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (taps_done) begin
                  tap_q     <= taps;
                  lfsr_q    <= SEED[SIZE-1:0];
                  bit_cnt_q <= 3'd0;
                  running_q <= 1'b1;
                  state_q   <= ST_RUN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (!taps_done) begin
                  // Selector went away: drop the partial byte and any pending one
                  dout_valid_q <= 1'b0;
                  bit_cnt_q    <= 3'd0;
                  running_q    <= 1'b0;
                  state_q      <= ST_IDLE;
               end else begin
                  if (step_s) begin
                     lfsr_q    <= lfsr_d;
                     sh_q      <= sh_d;
                     bit_cnt_q <= bit_cnt_d;
`ifdef LFSR_LOCKUP_RECOVERY_EN
                     lockup_q  <= lockup_d;
`endif
                  end else begin
                     lfsr_q <= lfsr_q;
                  end
                  if (step_s && wrap_s) begin
                     dout_q       <= {sh_q, out_bit_s};
                     dout_valid_q <= 1'b1;
                  end else if (accept_s) begin
                     dout_valid_q <= 1'b0;
                  end else begin
                     dout_valid_q <= dout_valid_q;
                  end
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               running_q <= 1'b0;
            end
         endcase
      end else begin
         state_q <= state_q;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign running    = running_q;
`ifdef LFSR_LOCKUP_RECOVERY_EN
   assign lockup     = lockup_q;
`endif

endmodule
